io_edge_capture: RTL and testbench
==================================

Name: io_edge_capture

Overview:
- Wishbone-readable event logger that timestamps edges on up to 8 project IO inputs.
- Events go into a small FIFO that firmware drains through the harness wishbone read path.
- Sits beside the project mux: consumes the selected project's io_in slice and feeds the harness wishbone data/ack return path at its own address window.
- Used for bring-up and debug of any project without the logic analyser.

Parameters:
- BASE_ADDR, 32'h30000500, base of 0x100-byte register window.
- WIDTH, 8, number of monitored inputs (1..8).
- DEPTH, 16, FIFO entries (power of two).
- TS_BITS, 24, timestamp counter width (WIDTH + TS_BITS must not exceed 32).

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high; clock clk
- wb_valid  in  1  cyc && stb from harness
- wb_we  in  1  write enable
- wb_sel  in  4  byte lane enables
- wb_adr  in  32  address
- wb_dat_i  in  32  write data
- wb_ack  out  1  acknowledge
- wb_dat_o  out  32  read data
- sample_in  in  WIDTH  asynchronous inputs to monitor
- not_empty  out  1  FIFO holds at least one event (LA/debug visibility)

Behaviour:
- Reset: wb_ack=0, wb_dat_o=0, not_empty=0, FIFO empty, overflow=0, ctrl=0, timestamp=0, sync/prev flops=0.
- Register map (offsets from BASE_ADDR; only word offsets 0x00–0x0C decoded, everything else ignored and never acked):
  - 0x00 CTRL (RW): bit0 enable; bit1 clear (write-1, self-clearing, reads 0); bits[8+WIDTH-1:8] edge mask. Writes honour wb_sel per byte lane.
  - 0x04 STATUS (RO): bits[4:0] count; bit8 empty; bit9 full; bit10 overflow (sticky).
  - 0x08 DATA (RO, pops FIFO): {zero pad, inputs[WIDTH-1:0] at bits[TS_BITS+WIDTH-1:TS_BITS], timestamp[TS_BITS-1:0]}. Reading DATA when empty returns 0 and does not pop.
  - 0x0C TIMER (RO): live timestamp.
- Input path: two-flop synchroniser on sample_in, then prev register.
  - An event occurs when enable && (((sync ^ prev) & mask) != 0).
  - The pushed entry is {sync, timestamp} for that cycle.
  - Latency from pin change to FIFO entry is 3 clk.
  - Simultaneous edges on several bits produce one entry.
- Timestamp: increments every clk while enable=1 and holds while enable=0. Wraps from 2^TS_BITS-1 to 0 with no flag.
- Wishbone handshake:
  - wb_ack registered: asserted exactly 1 cycle after a decoded wb_valid with wb_ack low.
  - wb_ack is high for 1 cycle only, then low for at least 1 cycle even if wb_valid is held.
  - wb_dat_o is valid in the ack cycle and 0 otherwise.
  - A DATA read pops exactly once per transaction, in the ack cycle.
  - Writes to RO registers are acked and ignored.
- FIFO boundaries:
  - Push when full with no pop in the same cycle: entry dropped, overflow set to 1.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only (the pop reads 0).
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Clear:
  - Same cycle as the CTRL write takes effect: FIFO emptied, overflow=0, timestamp=0, prev loaded from sync.
  - Clear has priority over a push in the same cycle.
  - Enable and mask take their newly written values.
- not_empty equals !empty, registered alongside the FIFO count.
- Reset mid-transaction drops the transaction with no ack. Reset mid-operation loses FIFO contents.

Decomposition:
- Shared package io_edge_capture_pkg: register offsets (REG_CTRL, REG_STATUS, REG_DATA, REG_TIMER) and CTRL bit positions.
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count, same-cycle push+pop rules as above.
- Decode, synchroniser, timestamp and wishbone logic stay in the top level.

Test Plan:
- CTRL=0x0000FF01, pulse sample_in[3] high at T then low at T+10 -> two entries; DATA reads give bit 27 set (inputs=0x08) then 0x00; timestamps differ by 10.
- Mask=0x01, toggle sample_in[1] only -> STATUS count stays 0, empty=1.
- 17 edges with DEPTH=16 and no reads -> STATUS=0x0000_0610 (count=16, full, overflow); first DATA read returns the oldest event.
- FIFO full, DATA read in the same cycle as a new edge -> count stays 16, overflow stays 0.
- Write CTRL=0x3 while full -> STATUS=0x100, TIMER reads a small value (<5); reading DATA when empty returns 0 and leaves count at 0.
- wb_valid held 4 cycles on STATUS -> ack pulses 1 cycle; a read of offset 0x20 -> no ack within 8 cycles.

Source files
------------

// File: rtl/io_edge_capture_pkg.sv
// rtl/io_edge_capture_pkg.sv - register offsets and CTRL/STATUS bit positions for io_edge_capture
package io_edge_capture_pkg;

   localparam logic [7:0] REG_CTRL   = 8'h00;
   localparam logic [7:0] REG_STATUS = 8'h04;
   localparam logic [7:0] REG_DATA   = 8'h08;
   localparam logic [7:0] REG_TIMER  = 8'h0C;

   localparam int CTRL_ENABLE_BIT  = 0;
   localparam int CTRL_CLEAR_BIT   = 1;
   localparam int CTRL_MASK_LSB    = 8;

   localparam int STATUS_EMPTY_BIT = 8;
   localparam int STATUS_FULL_BIT  = 9;
   localparam int STATUS_OVF_BIT   = 10;

   typedef enum logic [1:0] {
      SEL_CTRL,
      SEL_STATUS,
      SEL_DATA,
      SEL_TIMER
   } reg_sel_e;

endpackage

// File: rtl/io_edge_capture_sync_fifo.sv
// rtl/io_edge_capture_sync_fifo.sv - event FIFO with registered count/empty/full and drop indication
module sync_fifo #(
   parameter int  W     = 32,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          drop
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;
   logic [CW-1:0] count_next;

   // A pop on an empty FIFO is ignored; a push into a full FIFO survives only if a pop frees a slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop && !clear;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (do_push && !do_pop)
         count_next = count + 1'b1;
      else if (do_pop && !do_push)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == CW'(DEPTH));
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push)
               wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
               rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_edge_capture.sv
// rtl/io_edge_capture.sv - wishbone-readable timestamped edge logger for project IO inputs
module io_edge_capture
   import io_edge_capture_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h30000500,
   parameter int          WIDTH     = 8,
   parameter int          DEPTH     = 16,
   parameter int          TS_BITS   = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_valid,
   input  logic             wb_we,
   input  logic [3:0]       wb_sel,
   input  logic [31:0]      wb_adr,
   input  logic [31:0]      wb_dat_i,
   output logic             wb_ack,
   output logic [31:0]      wb_dat_o,
   input  logic [WIDTH-1:0] sample_in,
   output logic             not_empty
);

   localparam int EW = WIDTH + TS_BITS;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0]   sync_a;
   logic [WIDTH-1:0]   sync_b;
   logic [WIDTH-1:0]   prev;
   logic [WIDTH-1:0]   mask;
   logic               enable;
   logic               overflow;
   logic [TS_BITS-1:0] ts;

   logic               hit;
   reg_sel_e           sel;
   logic               start;
   logic               ctrl_wr;
   logic               clear;
   logic               pop;
   logic               event_hit;
   logic [31:0]        rdata;

   logic [EW-1:0]      fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic               fifo_drop;
   logic               unused_bits;

   assign unused_bits = ^{wb_dat_i, wb_sel[3:2]};

   always_comb begin
      hit = 1'b0;
      sel = SEL_CTRL;
      if (wb_valid && (wb_adr[31:8] == BASE_ADDR[31:8])) begin
         case (wb_adr[7:0])
            REG_CTRL:   begin hit = 1'b1; sel = SEL_CTRL;   end
            REG_STATUS: begin hit = 1'b1; sel = SEL_STATUS; end
            REG_DATA:   begin hit = 1'b1; sel = SEL_DATA;   end
            REG_TIMER:  begin hit = 1'b1; sel = SEL_TIMER;  end
            default:    hit = 1'b0;
         endcase
      end
   end

   // A held wb_valid restarts only after the ack cycle, so each access is seen exactly once.
   assign start     = hit && !wb_ack;
   assign ctrl_wr   = start && wb_we && (sel == SEL_CTRL);
   assign clear     = ctrl_wr && wb_sel[0] && wb_dat_i[CTRL_CLEAR_BIT];
   assign pop       = start && !wb_we && (sel == SEL_DATA);
   assign event_hit = enable && (((sync_b ^ prev) & mask) != '0);

   sync_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .push  (event_hit),
      .pop   (pop),
      .din   ({sync_b, ts}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .drop  (fifo_drop)
   );

   assign not_empty = !fifo_empty;

   always_comb begin
      rdata = '0;
      case (sel)
         SEL_CTRL: begin
            rdata[CTRL_ENABLE_BIT]           = enable;
            rdata[CTRL_MASK_LSB +: WIDTH]    = mask;
         end
         SEL_STATUS: begin
            rdata[CW-1:0]                    = fifo_count;
            rdata[STATUS_EMPTY_BIT]          = fifo_empty;
            rdata[STATUS_FULL_BIT]           = fifo_full;
            rdata[STATUS_OVF_BIT]            = overflow;
         end
         SEL_DATA: begin
            if (!fifo_empty)
               rdata[EW-1:0]                 = fifo_dout;
         end
         SEL_TIMER: rdata[TS_BITS-1:0]       = ts;
         default:   rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a   <= '0;
         sync_b   <= '0;
         prev     <= '0;
         mask     <= '0;
         enable   <= 1'b0;
         overflow <= 1'b0;
         ts       <= '0;
         wb_ack   <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         sync_a <= sample_in;
         sync_b <= sync_a;
         prev   <= sync_b;

         if (clear)
            ts <= '0;
         else if (enable)
            ts <= ts + 1'b1;

         if (clear)
            overflow <= 1'b0;
         else if (fifo_drop)
            overflow <= 1'b1;

         if (ctrl_wr) begin
            if (wb_sel[0])
               enable <= wb_dat_i[CTRL_ENABLE_BIT];
            if (wb_sel[1])
               mask <= wb_dat_i[CTRL_MASK_LSB +: WIDTH];
         end

         wb_ack   <= start;
         wb_dat_o <= (start && !wb_we) ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_io_edge_capture.sv
// tb/tb_io_edge_capture.sv - directed self-checking bench for io_edge_capture
module tb_io_edge_capture;

   localparam logic [31:0] BASE   = 32'h30000500;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_STAT = BASE + 32'h04;
   localparam logic [31:0] A_DATA = BASE + 32'h08;
   localparam logic [31:0] A_TIMR = BASE + 32'h0C;
   localparam logic [31:0] A_BAD  = BASE + 32'h20;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr;
   logic [31:0] wb_dat_i;
   logic        wb_ack;
   logic [31:0] wb_dat_o;
   logic [7:0]  sample_in;
   logic        not_empty;

   int checks = 0;
   int fails  = 0;

   io_edge_capture dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_sel    (wb_sel),
      .wb_adr    (wb_adr),
      .wb_dat_i  (wb_dat_i),
      .wb_ack    (wb_ack),
      .wb_dat_o  (wb_dat_o),
      .sample_in (sample_in),
      .not_empty (not_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output bit acked);
      @(posedge clk); #1;
      wb_valid = 1'b1;
      wb_we    = we;
      wb_adr   = addr;
      wb_dat_i = wdata;
      wb_sel   = 4'hF;
      acked    = 1'b0;
      rdata    = '0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         if (wb_ack) begin
            acked = 1'b1;
            rdata = wb_dat_o;
            break;
         end
      end
      wb_valid = 1'b0;
      wb_we    = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      bit a;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (wb_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b want 0", wb_ack); end
      checks++; if (wb_dat_o !== 32'h0) begin fails++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
      checks++; if (not_empty !== 1'b0) begin fails++; $display("FAIL reset_not_empty: got %b want 0", not_empty); end
      reset = 1'b0;
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000100) begin fails++; $display("FAIL reset_status: got %h want 00000100", d); end
      wb_xfer(1'b0, A_TIMR, 32'h0, d, a);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_timer: got %h want 0", d); end
      wb_xfer(1'b0, A_CTRL, 32'h0, d, a);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h want 0", d); end
   endtask

   task automatic test_edge_pulse();
      logic [31:0] d, d1, d2;
      logic [23:0] diff;
      bit a;
      wb_xfer(1'b1, A_CTRL, 32'h0000FF01, d, a);
      checks++; if (a !== 1'b1) begin fails++; $display("FAIL ctrl_write_ack: got %b want 1", a); end
      wb_xfer(1'b0, A_CTRL, 32'h0, d, a);
      checks++; if (d !== 32'h0000FF01) begin fails++; $display("FAIL ctrl_readback: got %h want 0000ff01", d); end
      @(posedge clk); #1 sample_in = 8'h08;
      repeat (10) @(posedge clk);
      #1 sample_in = 8'h00;
      repeat (6) @(posedge clk);
      #1;
      checks++; if (not_empty !== 1'b1) begin fails++; $display("FAIL pulse_not_empty: got %b want 1", not_empty); end
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000002) begin fails++; $display("FAIL pulse_status: got %h want 00000002", d); end
      wb_xfer(1'b0, A_DATA, 32'h0, d1, a);
      checks++; if (d1[31:24] !== 8'h08) begin fails++; $display("FAIL pulse_rise_inputs: got %h want 08", d1[31:24]); end
      wb_xfer(1'b0, A_DATA, 32'h0, d2, a);
      checks++; if (d2[31:24] !== 8'h00) begin fails++; $display("FAIL pulse_fall_inputs: got %h want 00", d2[31:24]); end
      diff = d2[23:0] - d1[23:0];
      checks++; if (diff !== 24'd10) begin fails++; $display("FAIL pulse_ts_delta: got %0d want 10", diff); end
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000100) begin fails++; $display("FAIL pulse_drained: got %h want 00000100", d); end
   endtask

   task automatic test_mask();
      logic [31:0] d;
      bit a;
      wb_xfer(1'b1, A_CTRL, 32'h00000103, d, a);
      @(posedge clk); #1 sample_in = 8'h02;
      repeat (3) @(posedge clk);
      #1 sample_in = 8'h00;
      repeat (6) @(posedge clk);
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000100) begin fails++; $display("FAIL mask_status: got %h want 00000100", d); end
      checks++; if (not_empty !== 1'b0) begin fails++; $display("FAIL mask_not_empty: got %b want 0", not_empty); end
   endtask

   task automatic test_overflow();
      logic [31:0] d, d1, d2;
      logic [23:0] diff;
      bit a;
      wb_xfer(1'b1, A_CTRL, 32'h0000FF03, d, a);
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1 sample_in[0] = ~sample_in[0];
         @(posedge clk);
      end
      repeat (5) @(posedge clk);
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000610) begin fails++; $display("FAIL ovf_status: got %h want 00000610", d); end
      wb_xfer(1'b0, A_DATA, 32'h0, d1, a);
      checks++; if (d1[31:24] !== 8'h01) begin fails++; $display("FAIL ovf_oldest_inputs: got %h want 01", d1[31:24]); end
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h0000040F) begin fails++; $display("FAIL ovf_sticky_status: got %h want 0000040f", d); end
      wb_xfer(1'b0, A_DATA, 32'h0, d2, a);
      checks++; if (d2[31:24] !== 8'h00) begin fails++; $display("FAIL ovf_second_inputs: got %h want 00", d2[31:24]); end
      diff = d2[23:0] - d1[23:0];
      checks++; if (diff !== 24'd2) begin fails++; $display("FAIL ovf_ts_delta: got %0d want 2", diff); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d;
      bit a;
      wb_xfer(1'b1, A_CTRL, 32'h0000FF03, d, a);
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1 sample_in[0] = ~sample_in[0];
         @(posedge clk);
      end
      repeat (5) @(posedge clk);
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000210) begin fails++; $display("FAIL full_status: got %h want 00000210", d); end
      // The edge reaches the FIFO three edges after the pin change, the same edge as the DATA pop.
      @(posedge clk); #1 sample_in[0] = ~sample_in[0];
      @(posedge clk);
      wb_xfer(1'b0, A_DATA, 32'h0, d, a);
      checks++; if (d[31:24] !== 8'h00) begin fails++; $display("FAIL full_pop_inputs: got %h want 00", d[31:24]); end
      repeat (5) @(posedge clk);
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000210) begin fails++; $display("FAIL full_pushpop_status: got %h want 00000210", d); end
   endtask

   task automatic test_clear_full();
      logic [31:0] d;
      bit a;
      wb_xfer(1'b1, A_CTRL, 32'h00000003, d, a);
      wb_xfer(1'b0, A_TIMR, 32'h0, d, a);
      checks++; if (!(d < 32'd5 && d > 32'd0)) begin fails++; $display("FAIL clear_timer: got %0d want 1..4", d); end
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000100) begin fails++; $display("FAIL clear_status: got %h want 00000100", d); end
      wb_xfer(1'b0, A_DATA, 32'h0, d, a);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL empty_data: got %h want 0", d); end
      checks++; if (a !== 1'b1) begin fails++; $display("FAIL empty_data_ack: got %b want 1", a); end
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000100) begin fails++; $display("FAIL empty_read_status: got %h want 00000100", d); end
      wb_xfer(1'b0, A_CTRL, 32'h0, d, a);
      checks++; if (d !== 32'h00000001) begin fails++; $display("FAIL clear_ctrl_readback: got %h want 00000001", d); end
   endtask

   task automatic test_handshake();
      logic [3:0]  pattern;
      logic [31:0] ack_data;
      logic [31:0] d;
      int          idle_nonzero;
      bit          a;
      pattern      = '0;
      ack_data     = '0;
      idle_nonzero = 0;
      @(posedge clk); #1;
      wb_valid = 1'b1; wb_we = 1'b0; wb_adr = A_STAT; wb_sel = 4'hF;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pattern[i] = wb_ack;
         if (wb_ack && i == 0) ack_data = wb_dat_o;
         if (!wb_ack && wb_dat_o != 32'h0) idle_nonzero++;
      end
      wb_valid = 1'b0;
      checks++; if (pattern !== 4'b0101) begin fails++; $display("FAIL held_ack_pattern: got %b want 0101", pattern); end
      checks++; if (ack_data !== 32'h00000100) begin fails++; $display("FAIL held_ack_data: got %h want 00000100", ack_data); end
      checks++; if (idle_nonzero !== 0) begin fails++; $display("FAIL idle_dat_zero: got %0d nonzero idle cycles want 0", idle_nonzero); end
      wb_xfer(1'b0, A_BAD, 32'h0, d, a);
      checks++; if (a !== 1'b0) begin fails++; $display("FAIL undecoded_ack: got %b want 0", a); end
      wb_xfer(1'b1, A_STAT, 32'hFFFFFFFF, d, a);
      checks++; if (a !== 1'b1) begin fails++; $display("FAIL ro_write_ack: got %b want 1", a); end
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000100) begin fails++; $display("FAIL ro_write_ignored: got %h want 00000100", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bit a;
      wb_xfer(1'b1, A_CTRL, 32'h0000FF01, d, a);
      @(posedge clk); #1 sample_in[5] = ~sample_in[5];
      repeat (5) @(posedge clk);
      #1;
      checks++; if (not_empty !== 1'b1) begin fails++; $display("FAIL premid_not_empty: got %b want 1", not_empty); end
      wb_valid = 1'b1; wb_we = 1'b0; wb_adr = A_STAT; wb_sel = 4'hF;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (wb_ack !== 1'b0) begin fails++; $display("FAIL mid_reset_ack: got %b want 0", wb_ack); end
      wb_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (wb_ack !== 1'b0) begin fails++; $display("FAIL post_reset_ack: got %b want 0", wb_ack); end
      wb_xfer(1'b0, A_STAT, 32'h0, d, a);
      checks++; if (d !== 32'h00000100) begin fails++; $display("FAIL mid_reset_status: got %h want 00000100", d); end
   endtask

   initial begin
      reset     = 1'b1;
      wb_valid  = 1'b0;
      wb_we     = 1'b0;
      wb_sel    = 4'h0;
      wb_adr    = 32'h0;
      wb_dat_i  = 32'h0;
      sample_in = 8'h00;
      test_reset();
      test_edge_pulse();
      test_mask();
      test_overflow();
      test_full_push_pop();
      test_clear_full();
      test_handshake();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
